// File: rtl/wshb_arb_pkg.sv
// Shared types and field widths for the two-master Wishbone classic arbiter.
package wshb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int CTI_W = 3;
  localparam int BTE_W = 2;

endpackage

// File: rtl/wshb_arbiter.sv
// Fixed-priority Wishbone classic arbiter: m0 (display reader) wins contention,
// m1 (frame-buffer writer) is preempted at an acked transfer after MAX_BURST acks.
module wshb_arbiter
  import wshb_arb_pkg::*;
#(
  parameter int MAX_BURST = 16,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_cyc,
  input  logic               m0_stb,
  input  logic               m0_we,
  input  logic [AW-1:0]      m0_adr,
  input  logic [DW-1:0]      m0_dat_ms,
  input  logic [DW/8-1:0]    m0_sel,
  input  logic [CTI_W-1:0]   m0_cti,
  input  logic [BTE_W-1:0]   m0_bte,
  output logic               m0_ack,
  input  logic               m1_cyc,
  input  logic               m1_stb,
  input  logic               m1_we,
  input  logic [AW-1:0]      m1_adr,
  input  logic [DW-1:0]      m1_dat_ms,
  input  logic [DW/8-1:0]    m1_sel,
  input  logic [CTI_W-1:0]   m1_cti,
  input  logic [BTE_W-1:0]   m1_bte,
  output logic               m1_ack,
  output logic [DW-1:0]      m_dat_sm,
  output logic               s_cyc,
  output logic               s_stb,
  output logic               s_we,
  output logic [AW-1:0]      s_adr,
  output logic [DW-1:0]      s_dat_ms,
  output logic [DW/8-1:0]    s_sel,
  output logic [CTI_W-1:0]   s_cti,
  output logic [BTE_W-1:0]   s_bte,
  input  logic               s_ack,
  input  logic [DW-1:0]      s_dat_sm,
  output logic [1:0]         gnt
);

  // Keep the counter at least one bit wide so MAX_BURST = 0 still elaborates.
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BW-1:0] BCNT_SAT  = BW'(MAX_BURST);
  localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

  arb_state_t     st;
  arb_state_t     st_nxt;
  logic [BW-1:0]  bcnt;
  logic           preempt;

  assign preempt  = (MAX_BURST > 0) && s_ack && m0_cyc && (bcnt == BCNT_LAST);
  assign m_dat_sm = s_dat_sm;

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE: begin
        if (m0_cyc) begin
          st_nxt = GNT0;
        end else if (m1_cyc) begin
          st_nxt = GNT1;
        end else begin
          st_nxt = IDLE;
        end
      end
      GNT0: begin
        if (!m0_cyc) begin
          st_nxt = IDLE;
        end else begin
          st_nxt = GNT0;
        end
      end
      // Always pass through IDLE so the slave sees s_cyc low between owners.
      GNT1: begin
        if (!m1_cyc || preempt) begin
          st_nxt = IDLE;
        end else begin
          st_nxt = GNT1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  // Held at zero outside GNT1, so every new m1 grant starts counting from 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
    end else if (st != GNT1) begin
      bcnt <= '0;
    end else if (s_ack && (bcnt != BCNT_SAT)) begin
      bcnt <= bcnt + 1'b1;
    end else begin
      bcnt <= bcnt;
    end
  end

  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    s_cti    = '0;
    s_bte    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    gnt      = 2'b00;
    case (st)
      GNT0: begin
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        s_we     = m0_we;
        s_adr    = m0_adr;
        s_dat_ms = m0_dat_ms;
        s_sel    = m0_sel;
        s_cti    = m0_cti;
        s_bte    = m0_bte;
        m0_ack   = s_ack;
        gnt      = 2'b01;
      end
      GNT1: begin
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        s_we     = m1_we;
        s_adr    = m1_adr;
        s_dat_ms = m1_dat_ms;
        s_sel    = m1_sel;
        s_cti    = m1_cti;
        s_bte    = m1_bte;
        m1_ack   = s_ack;
        gnt      = 2'b10;
      end
      default: begin
        gnt = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_wshb_arbiter.sv
// Directed bench: instance a uses MAX_BURST = 4, instance b MAX_BURST = 0, sharing stimulus.
module tb_wshb_arbiter;

  logic        clk, rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack;
  logic [31:0] m0_adr, m0_dat_ms, m1_adr, m1_dat_ms, s_dat_sm;
  logic [3:0]  m0_sel, m1_sel;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;

  logic        a_m0_ack, a_m1_ack, a_s_cyc, a_s_stb, a_s_we;
  logic [31:0] a_m_dat_sm, a_s_adr, a_s_dat_ms;
  logic [3:0]  a_s_sel;
  logic [2:0]  a_s_cti;
  logic [1:0]  a_s_bte, a_gnt;
  logic        b_m0_ack, b_m1_ack, b_s_cyc, b_s_stb, b_s_we;
  logic [31:0] b_m_dat_sm, b_s_adr, b_s_dat_ms;
  logic [3:0]  b_s_sel;
  logic [2:0]  b_s_cti;
  logic [1:0]  b_s_bte, b_gnt;

  int n_cmp = 0;
  int n_err = 0;

  wshb_arbiter #(.MAX_BURST(4), .AW(32), .DW(32)) dut_a (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(a_m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(a_m1_ack),
    .m_dat_sm(a_m_dat_sm), .s_cyc(a_s_cyc), .s_stb(a_s_stb), .s_we(a_s_we), .s_adr(a_s_adr),
    .s_dat_ms(a_s_dat_ms), .s_sel(a_s_sel), .s_cti(a_s_cti), .s_bte(a_s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(a_gnt)
  );

  wshb_arbiter #(.MAX_BURST(0), .AW(32), .DW(32)) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_dat_ms(m0_dat_ms),
    .m0_sel(m0_sel), .m0_cti(m0_cti), .m0_bte(m0_bte), .m0_ack(b_m0_ack),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_dat_ms(m1_dat_ms),
    .m1_sel(m1_sel), .m1_cti(m1_cti), .m1_bte(m1_bte), .m1_ack(b_m1_ack),
    .m_dat_sm(b_m_dat_sm), .s_cyc(b_s_cyc), .s_stb(b_s_stb), .s_we(b_s_we), .s_adr(b_s_adr),
    .s_dat_ms(b_s_dat_ms), .s_sel(b_s_sel), .s_cti(b_s_cti), .s_bte(b_s_bte),
    .s_ack(s_ack), .s_dat_sm(s_dat_sm), .gnt(b_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An ack seen while the arbiter is idle must never reach either master.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(a_gnt == 2'b00 && (a_m0_ack || a_m1_ack)) && !(b_gnt == 2'b00 && (b_m0_ack || b_m1_ack)))
        else $error("FAIL ack_in_idle a=%b%b b=%b%b required 00", a_m0_ack, a_m1_ack, b_m0_ack, b_m1_ack);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_cmp++; if (a_gnt !== 2'b00 || a_s_cyc !== 1'b0) begin n_err++;
      $display("FAIL reset_hold gnt=%b s_cyc=%b required 00/0", a_gnt, a_s_cyc); end
    rst = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_0100;
    step();
    n_cmp++; if (a_gnt !== 2'b01) begin n_err++;
      $display("FAIL reset_pre_gnt gnt=%b required 01", a_gnt); end
    s_ack = 1'b1;
    #1;
    n_cmp++; if (a_m0_ack !== 1'b1) begin n_err++;
      $display("FAIL reset_pre_ack m0_ack=%b required 1", a_m0_ack); end
    rst = 1'b1;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0 || a_s_stb !== 1'b0 || a_m0_ack !== 1'b0 || a_gnt !== 2'b00) begin n_err++;
      $display("FAIL reset_async s_cyc=%b s_stb=%b m0_ack=%b gnt=%b required 0/0/0/00",
               a_s_cyc, a_s_stb, a_m0_ack, a_gnt); end
    n_cmp++; if (b_s_cyc !== 1'b0 || b_m0_ack !== 1'b0 || b_gnt !== 2'b00) begin n_err++;
      $display("FAIL reset_async_b s_cyc=%b m0_ack=%b gnt=%b required 0/0/00", b_s_cyc, b_m0_ack, b_gnt); end
    #1;
    rst = 1'b0; s_ack = 1'b0;
    #1;
    n_cmp++; if (a_gnt !== 2'b00 || a_s_adr !== 32'h0) begin n_err++;
      $display("FAIL reset_release gnt=%b s_adr=%h required 00/0", a_gnt, a_s_adr); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
  endtask

  task automatic test_simultaneous();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_1000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_2000;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++;
      $display("FAIL simul_latency s_cyc=%b required 0", a_s_cyc); end
    step();
    n_cmp++; if (a_gnt !== 2'b01 || a_s_adr !== 32'h0000_1000) begin n_err++;
      $display("FAIL simul_gnt gnt=%b s_adr=%h required 01/00001000", a_gnt, a_s_adr); end
    s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (a_m0_ack !== 1'b1 || a_m1_ack !== 1'b0) begin n_err++;
        $display("FAIL simul_ack[%0d] m0_ack=%b m1_ack=%b required 1/0", i, a_m0_ack, a_m1_ack); end
      step();
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0 || a_gnt !== 2'b01) begin n_err++;
      $display("FAIL simul_drop s_cyc=%b gnt=%b required 0/01", a_s_cyc, a_gnt); end
    step();
    n_cmp++; if (a_gnt !== 2'b00) begin n_err++;
      $display("FAIL simul_idle gnt=%b required 00", a_gnt); end
    step();
    n_cmp++; if (a_gnt !== 2'b10 || a_s_adr !== 32'h0000_2000) begin n_err++;
      $display("FAIL simul_m1 gnt=%b s_adr=%h required 10/00002000", a_gnt, a_s_adr); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step(); step();
  endtask

  task automatic test_m1_write();
    int acks = 0;
    logic [31:0] exp_dat;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_sel = 4'hF; m1_adr = 32'h0; m1_dat_ms = 32'hA000_0000;
    step();
    for (int i = 0; i < 8; i++) begin
      exp_dat = 32'hA000_0000 + 32'(i);
      m1_adr = 32'(i) * 32'd4; m1_dat_ms = exp_dat; s_ack = 1'b1;
      #1;
      if (a_m1_ack === 1'b1) acks++;
      n_cmp++; if (a_gnt !== 2'b10 || a_s_we !== 1'b1 || a_s_dat_ms !== exp_dat || a_s_adr !== 32'(i) * 32'd4
                   || a_s_sel !== 4'hF) begin n_err++;
        $display("FAIL m1_write[%0d] gnt=%b we=%b dat=%h adr=%h required 10/1/%h/%h",
                 i, a_gnt, a_s_we, a_s_dat_ms, a_s_adr, exp_dat, 32'(i) * 32'd4); end
      step();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
    n_cmp++; if (acks !== 8) begin n_err++;
      $display("FAIL m1_write_acks got=%0d required 8", acks); end
    step(); step();
  endtask

  task automatic test_preempt();
    int a_acks = 0;
    logic [1:0] exp_gnt [6] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01};
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_3000;
    step();
    s_ack = 1'b1;
    step(); step();
    m0_cyc = 1'b1; m0_stb = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (a_m1_ack === 1'b1) a_acks++;
      n_cmp++; if (a_gnt !== exp_gnt[c] || a_m0_ack !== exp_gnt[c][0]) begin n_err++;
        $display("FAIL preempt_a[%0d] gnt=%b m0_ack=%b required %b/%b", c, a_gnt, a_m0_ack, exp_gnt[c], exp_gnt[c][0]); end
      n_cmp++; if (b_gnt !== 2'b10 || b_m1_ack !== 1'b1) begin n_err++;
        $display("FAIL preempt_b[%0d] gnt=%b m1_ack=%b required 10/1", c, b_gnt, b_m1_ack); end
      step();
    end
    n_cmp++; if (a_acks !== 2) begin n_err++;
      $display("FAIL preempt_extra_acks got=%0d required 2", a_acks); end
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    step(); step();
    // m1 regranted in a; raising m0 now must still allow a full 4 acks
    n_cmp++; if (a_gnt !== 2'b10) begin n_err++;
      $display("FAIL preempt_resume gnt=%b required 10", a_gnt); end
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1; a_acks = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (a_m1_ack === 1'b1) a_acks++;
      step();
    end
    n_cmp++; if (a_acks !== 4 || a_gnt !== 2'b01) begin n_err++;
      $display("FAIL preempt_restart acks=%0d gnt=%b required 4/01", a_acks, a_gnt); end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    #1;
    n_cmp++; if (b_s_cyc !== 1'b0 || b_gnt !== 2'b10) begin n_err++;
      $display("FAIL noburst_drop s_cyc=%b gnt=%b required 0/10", b_s_cyc, b_gnt); end
    step();
    n_cmp++; if (b_gnt !== 2'b00) begin n_err++;
      $display("FAIL noburst_idle gnt=%b required 00", b_gnt); end
    step();
    n_cmp++; if (b_gnt !== 2'b01) begin n_err++;
      $display("FAIL noburst_gnt0 gnt=%b required 01", b_gnt); end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step(); step();
  endtask

  task automatic test_handover();
    logic [31:0] pat [4] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 32'h1234_5678};
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h0000_4000;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h0000_5000;
    step();
    for (int i = 0; i < 4; i++) begin
      s_dat_sm = pat[i];
      #1;
      n_cmp++; if (a_m_dat_sm !== pat[i] || b_m_dat_sm !== pat[i]) begin n_err++;
        $display("FAIL dat_bcast[%0d] a=%h b=%h required %h", i, a_m_dat_sm, b_m_dat_sm, pat[i]); end
    end
    m0_cyc = 1'b0; m0_stb = 1'b0;
    #1;
    n_cmp++; if (a_s_cyc !== 1'b0) begin n_err++;
      $display("FAIL handover_drop s_cyc=%b required 0", a_s_cyc); end
    step();
    n_cmp++; if (a_gnt !== 2'b00 || a_s_cyc !== 1'b0 || a_s_adr !== 32'h0) begin n_err++;
      $display("FAIL handover_gap gnt=%b s_cyc=%b s_adr=%h required 00/0/0", a_gnt, a_s_cyc, a_s_adr); end
    step();
    n_cmp++; if (a_gnt !== 2'b10 || a_s_cyc !== 1'b1 || a_s_adr !== 32'h0000_5000) begin n_err++;
      $display("FAIL handover_gnt1 gnt=%b s_cyc=%b s_adr=%h required 10/1/00005000", a_gnt, a_s_cyc, a_s_adr); end
    m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_dat_sm = 32'h0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 32'h0; m0_dat_ms = 32'h0;
    m0_sel = 4'hF; m0_cti = 3'b000; m0_bte = 2'b00;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 32'h0; m1_dat_ms = 32'h0;
    m1_sel = 4'hF; m1_cti = 3'b010; m1_bte = 2'b00;
    test_reset();
    test_simultaneous();
    test_m1_write();
    test_preempt();
    test_handover();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
